// File: rtl/data_memory_be.sv
// data_memory_be: synchronous byte-enabled data memory with registered reads, address checking and post-reset clear
// Ports: clk, reset (sync, active-high); address (byte address), write_data, byte_en (per-lane write enable),
//        mem_read / mem_write (request strobes); read_data (registered load data), read_valid (1-cycle pulse),
//        ready (clear finished), addr_error (1-cycle pulse on a rejected request).
module data_memory_be #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    mem_read,
    input  logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    ready,
    output logic                    addr_error
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IW-1:0]         idx;
    logic                  bad, run, rd_ok, wr_ok;

    // Range check uses the full word address so out-of-range addresses never alias onto low words.
    assign word_addr = address >> OFF;
    assign idx       = word_addr[IW-1:0];
    assign bad       = ((address & OFF_MASK) != '0) || (64'(word_addr) >= 64'(DEPTH));
    assign run       = (state == RUN);
    assign rd_ok     = run && mem_read && !bad;
    // A simultaneous read and write performs the read only.
    assign wr_ok     = run && mem_write && !mem_read && !bad;

    always_comb begin
        state_nx = state;
        if (state == CLEAR && cnt == IW'(DEPTH - 1)) state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            addr_error <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= (state == CLEAR) ? cnt + 1'b1 : cnt;
            ready      <= (state_nx == RUN);
            read_valid <= rd_ok;
            addr_error <= run && (mem_read || mem_write) && bad;
            if (rd_ok) read_data <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (!reset && wr_ok) begin
            for (int b = 0; b < BYTES; b++)
                if (byte_en[b]) mem[idx][8*b +: 8] <= write_data[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: table-driven self-checking bench for data_memory_be
module tb_data_memory_be;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        read_valid;
    logic        ready;
    logic        addr_error;

    int checks = 0;
    int errors = 0;

    data_memory_be #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .byte_en(byte_en), .mem_read(mem_read), .mem_write(mem_write),
        .read_data(read_data), .read_valid(read_valid), .ready(ready), .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_rv;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        byte_en    = be;
    endtask

    // Apply one cycle of inputs, then sample just after the edge that consumed them.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        drive(rd, wr, a, d, be);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        vecs[0]  = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 1'b1, 32'h010, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEAA};
        vecs[8]  = '{1'b0, 1'b1, 32'h010, 32'h12345678, 4'hC, 1'b0, 1'b0, 32'hDEADBEAA};
        vecs[9]  = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'h1234BEAA};
        vecs[10] = '{1'b1, 1'b0, 32'h011, 32'h0,        4'h0, 1'b0, 1'b1, 32'h1234BEAA};
        vecs[11] = '{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'h1234BEAA};
        vecs[12] = '{1'b1, 1'b0, 32'h400, 32'h0,        4'h0, 1'b0, 1'b1, 32'h1234BEAA};
        vecs[13] = '{1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h1234BEAA};
        vecs[14] = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 32'h020, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h020, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 32'h014, 32'hCAFEF00D, 4'h0, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 32'h014, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b1, 32'h3FC, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[20] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'h0, 1'b1, 1'b0, 32'h11223344};
        vecs[21] = '{1'b1, 1'b0, 32'h3FD, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11223344};
        vecs[22] = '{1'b0, 1'b1, 32'h012, 32'h55555555, 4'hF, 1'b0, 1'b1, 32'h11223344};
        vecs[23] = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'h1234BEAA};

        // Reset held for two edges: all outputs cleared, memory not yet ready.
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_read_valid", 32'(read_valid), 32'h0);
        check("reset_addr_error", 32'(addr_error), 32'h0);
        check("reset_read_data", read_data, 32'h0);
        reset = 1'b0;
        wait_ready(n);
        check("clear_cycles", 32'(n), 32'd256);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d_read_valid", i), 32'(read_valid), 32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_addr_error", i), 32'(addr_error), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'h1);
        end

        // Pulses last exactly one cycle.
        step(1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rv_pulse_drop", 32'(read_valid), 32'h0);
        check("rv_pulse_hold", read_data, 32'h11223344);
        step(1'b1, 1'b0, 32'h401, 32'h0, 4'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("err_pulse_drop", 32'(addr_error), 32'h0);

        // Reset mid-operation restarts the clear and wipes earlier stores.
        step(1'b0, 1'b1, 32'h008, 32'h00000005, 4'hF);
        step(1'b1, 1'b0, 32'h008, 32'h0, 4'h0);
        check("pre_reset_read", read_data, 32'h5);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b0;
        check("rst2_ready", 32'(ready), 32'h0);
        check("rst2_read_data", read_data, 32'h0);
        step(1'b1, 1'b0, 32'h008, 32'h0, 4'h0);
        check("clear_read_valid", 32'(read_valid), 32'h0);
        check("clear_addr_error", 32'(addr_error), 32'h0);
        step(1'b1, 1'b0, 32'h009, 32'h0, 4'h0);
        check("clear_misaligned_err", 32'(addr_error), 32'h0);
        wait_ready(n);
        check("clear2_cycles", 32'(n), 32'd254);
        step(1'b1, 1'b0, 32'h008, 32'h0, 4'h0);
        check("post_clear_rv", 32'(read_valid), 32'h1);
        check("post_clear_data", read_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
